ascon_xof_trimmer: RTL and testbench

Downstream output stage for the Ascon accelerator's Hash/XOF squeeze path. It consumes the 64-bit digest stream from the accelerator's master AXI4-Stream port and truncates it to a software-requested byte length L. It generates the final partial `tkeep` and `tlast`, and pulses `abort_o` back to the hash controller to stop continuous squeezing. Any surplus beats already in flight are discarded before the block returns to idle.

---
 rtl/ascon_pkg.sv | 23 ++
 rtl/ascon_axis_skid.sv | 95 +++++++++
 rtl/ascon_xof_trimmer.sv | 142 ++++++++++++++
 tb/tb_ascon_xof_trimmer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon accelerator datapath blocks.
package ascon_pkg;

  typedef logic [2:0] axi_tuser_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } trim_state_t;

  // Low-byte keep mask for n valid bytes; anything from 8 up is a full lane.
  function automatic logic [7:0] keep_from_bytes(logic [3:0] n);
    logic [15:0] ones;
    if (n >= 4'd8) begin
      return 8'hFF;
    end
    ones = (16'd1 << n) - 16'd1;
    return ones[7:0];
  endfunction

endpackage

// File: rtl/ascon_axis_skid.sv
// AXI4-Stream output register slice: 2-entry skid buffer with registered
// s_ready when ASCON_TRIM_SKID_EN is defined, otherwise a single register.
module ascon_axis_skid #(
  parameter int W = 76
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         empty_o
);

  // A beat moves on a side when valid && ready at posedge clk; a held beat
  // keeps valid and data stable until taken, and ready never looks at valid.
`ifdef ASCON_TRIM_SKID_EN
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (main_v_q && m_ready) begin
      main_v_d = skid_v_q;
      if (skid_v_q) main_d = skid_q;
      skid_v_d = 1'b0;
    end
    if (s_valid && rdy_q) begin
      if (!main_v_d) begin
        main_v_d = 1'b1;
        main_d   = s_data;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = s_data;
      end
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign s_ready = rdy_q;
  assign empty_o = !main_v_q && !skid_v_q;
`else
  logic         main_v_q, main_v_d;
  logic [W-1:0] main_q, main_d;

  assign s_ready = !main_v_q || m_ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    if (m_ready) main_v_d = 1'b0;
    if (s_valid && s_ready) begin
      main_v_d = 1'b1;
      main_d   = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

  assign empty_o = !main_v_q;
`endif

  assign m_valid = main_v_q;
  assign m_data  = main_q;

endmodule

// File: rtl/ascon_xof_trimmer.sv
// Truncates the Ascon XOF squeeze stream to L bytes, aborts the squeeze and
// drains surplus beats. Output slice form is selected by ASCON_TRIM_SKID_EN.
module ascon_xof_trimmer
  import ascon_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TUSER_WIDTH = 3,
  parameter int C_LEN_WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [C_LEN_WIDTH-1:0]          len_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            abort_o,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output trim_state_t                     dbg_state_o
);

  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int PW = C_AXIS_TUSER_WIDTH + 1 + KW + C_AXIS_TDATA_WIDTH;

  trim_state_t              state_q, state_d;
  logic [C_LEN_WIDTH-1:0]   rem_q, rem_d;
  logic                     abort_q, abort_d, done_q, done_d;
  logic                     sk_s_ready, sk_empty, push;
  logic [KW-1:0]            out_keep;
  logic                     out_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_data;
  logic                     rem_gt8;

  assign rem_gt8 = rem_q > C_LEN_WIDTH'(8);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    abort_d       = 1'b0;
    done_d        = 1'b0;
    s_axis_tready = 1'b0;
    out_keep      = '1;
    out_last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d = len_i;
          if (len_i == '0) begin
            state_d = FIN;
            abort_d = 1'b1;
          end else begin
            state_d = PASS;
          end
        end
      end
      PASS: begin
        s_axis_tready = sk_s_ready;
        // Upstream tlast before L is reached ends the run without an abort.
        if (rem_gt8) begin
          if (s_axis_tlast) begin
            out_keep = s_axis_tkeep;
            out_last = 1'b1;
          end
        end else begin
          out_keep = keep_from_bytes(rem_q[3:0]);
          out_last = 1'b1;
        end
        if (s_axis_tvalid && sk_s_ready) begin
          if (rem_gt8) begin
            if (s_axis_tlast) state_d = FIN;
            else              rem_d   = rem_q - C_LEN_WIDTH'(8);
          end else begin
            abort_d = 1'b1;
            state_d = s_axis_tlast ? FIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        s_axis_tready = 1'b1;
        if (!s_axis_tvalid || s_axis_tlast) state_d = FIN;
      end
      FIN: begin
        if (sk_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < KW; i++) begin
      out_data[8*i +: 8] = s_axis_tdata[8*i +: 8] & {8{out_keep[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  assign push = (state_q == PASS) && s_axis_tvalid && sk_s_ready;

  ascon_axis_skid #(.W(PW)) u_out (
    .clk     (clk),
    .rst     (rst),
    .s_valid (push),
    .s_ready (sk_s_ready),
    .s_data  ({s_axis_tuser, out_last, out_keep, out_data}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  ({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
    .empty_o (sk_empty)
  );

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ascon_xof_trimmer.sv
// Scoreboard bench for ascon_xof_trimmer: directed lengths, backpressure,
// early upstream tlast and mid-run reset.
module tb_ascon_xof_trimmer;
  import ascon_pkg::*;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 3;
  localparam int LW = 32;
  localparam int PW = UW + 1 + KW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, abort_o;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  axi_tuser_t    s_tuser, m_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic          m_tlast, m_tvalid, m_tready;
  trim_state_t   dbg_state;

  always #5 clk = ~clk;

  ascon_xof_trimmer #(
    .C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .dbg_state_o(dbg_state)
  );

  wire [PW-1:0] m_payload = {m_tuser, m_tlast, m_tkeep, m_tdata};

  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int abort_cnt = 0, done_cnt = 0, abort_cyc = -1, beats_out = 0;
  int hs_cyc[16];
  int rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // clock/reset and downstream ready: 0 = hold low, 1 = hold high, 2 = random
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic [PW-1:0] held = '0;
  bit held_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check_int("stall_valid", int'(m_tvalid), 1);
        check("stall_payload", m_payload, held);
      end
      held_v = m_tvalid && !m_tready;
      held   = m_payload;
      if (m_tvalid && m_tready) begin
        beats_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", m_payload);
        end else begin
          check("beat", m_payload, exp_q.pop_front());
        end
      end
      if (abort_o) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (done_o) done_cnt++;
    end
  end

  // driver tasks
  function automatic logic [DW-1:0] data_of(input int t, input int i);
    return {8'(t), 8'(i), 48'hC3B4_A596_8778};
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input axi_tuser_t u, input logic l);
    exp_q.push_back({u, l, k, d});
  endtask

  task automatic start_op(input int len, output int st_cyc);
    abort_cnt = 0;
    done_cnt  = 0;
    abort_cyc = -1;
    start_i   = 1'b1;
    len_i     = LW'(len);
    st_cyc    = cyc;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
  endtask

  task automatic send_beat(input int t, input int idx, input logic [KW-1:0] k, input logic l);
    int  waited = 0;
    bit  hs = 1'b0;
    s_tdata  = data_of(t, idx);
    s_tkeep  = k;
    s_tuser  = axi_tuser_t'(idx);
    s_tlast  = l;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      hs = s_tready;
      if (hs) hs_cyc[idx] = cyc;
      @(posedge clk);
      #1;
      waited++;
    end while (!hs && waited < 200);
    if (!hs) begin
      n_cmp++;
      n_err++;
      $display("FAIL s_handshake_timeout: beat %0d not accepted, got ready=0 expected 1", idx);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (done_cnt == 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_int({tag, "_done_cnt"}, done_cnt, 1);
    check_int({tag, "_busy_after"}, int'(busy_o), 0);
    check_int({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_flags"}, int'({busy_o, done_o, abort_o, s_tready, m_tvalid}), 0);
    check({tag, "_m_payload"}, m_payload, '0);
  endtask

  int st_cyc;
  int beats_before;

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // L=20: FF, FF, 0F; two surplus beats flushed
    push_exp(data_of(1, 0), 8'hFF, 3'd0, 1'b0);
    push_exp(data_of(1, 1), 8'hFF, 3'd1, 1'b0);
    push_exp(64'h0000_0000_A596_8778, 8'h0F, 3'd2, 1'b1);
    start_op(20, st_cyc);
    for (int i = 0; i < 5; i++) send_beat(1, i, 8'hFF, i == 4);
    wait_done("l20");
    check_int("l20_abort_cnt", abort_cnt, 1);
    check_int("l20_abort_cyc", abort_cyc, hs_cyc[2] + 1);

    // L=16: exact two full lanes, flush ends on idle upstream
    push_exp(data_of(2, 0), 8'hFF, 3'd0, 1'b0);
    push_exp(data_of(2, 1), 8'hFF, 3'd1, 1'b1);
    start_op(16, st_cyc);
    for (int i = 0; i < 2; i++) send_beat(2, i, 8'hFF, 1'b0);
    wait_done("l16");
    check_int("l16_abort_cnt", abort_cnt, 1);
    check_int("l16_abort_cyc", abort_cyc, hs_cyc[1] + 1);

    // L=0: no beats, immediate abort
    beats_before = beats_out;
    start_op(0, st_cyc);
    wait_done("l0");
    check_int("l0_abort_cnt", abort_cnt, 1);
    check_int("l0_abort_cyc", abort_cyc, st_cyc + 1);
    check_int("l0_beats", beats_out - beats_before, 0);

    // L=64 under random downstream backpressure
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) push_exp(data_of(4, i), 8'hFF, axi_tuser_t'(i), i == 7);
    start_op(64, st_cyc);
    for (int i = 0; i < 8; i++) send_beat(4, i, 8'hFF, 1'b0);
    wait_done("l64");
    check_int("l64_abort_cnt", abort_cnt, 1);
    rdy_mode = 1;

    // L=100 with upstream tlast on beat 4: no abort
    for (int i = 0; i < 4; i++) push_exp(data_of(5, i), 8'hFF, axi_tuser_t'(i), i == 3);
    start_op(100, st_cyc);
    for (int i = 0; i < 4; i++) send_beat(5, i, 8'hFF, i == 3);
    wait_done("l100");
    check_int("l100_abort_cnt", abort_cnt, 0);

    // Reset during PASS of L=40 with beats stuck downstream, then L=8
    rdy_mode = 0;
    start_op(40, st_cyc);
    send_beat(6, 0, 8'hFF, 1'b0);
    s_tdata = data_of(6, 1); s_tkeep = 8'hFF; s_tuser = 3'd1; s_tlast = 1'b0;
    s_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    push_exp(data_of(7, 0), 8'hFF, 3'd0, 1'b1);
    start_op(8, st_cyc);
    send_beat(7, 0, 8'hFF, 1'b0);
    wait_done("l8");
    check_int("l8_abort_cnt", abort_cnt, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
